// File: rtl/hex_mul_seq_pkg.sv
// Shared definitions for the nibble-serial hex multiplier: widths, the state
// code seen by both the sequencer and the datapath, and the nibble mux.
package hex_mul_pkg;

    localparam int unsigned OP_W    = 8;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned PROD_W  = 2 * OP_W;

    // Numeric values are part of the datapath contract; do not reorder.
    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        COMPUTE_1 = 3'd1,
        COMPUTE_2 = 3'd2,
        COMPUTE_3 = 3'd3,
        COMPUTE_4 = 3'd4,
        COMPUTE_5 = 3'd5,
        COMPUTE_6 = 3'd6
    } state_e;

    typedef struct packed {
        logic [NIB_W-1:0] in_1;
        logic [NIB_W-1:0] in_2;
    } nib_pair_t;

    // Nibble pair issued to the datapath in each state; zero outside C1..C4.
    function automatic nib_pair_t nib_sel(input state_e          state,
                                          input logic [OP_W-1:0] a,
                                          input logic [OP_W-1:0] b);
        nib_pair_t p;
        p = '0;
        case (state)
            COMPUTE_1: begin
                p.in_1 = a[NIB_W-1:0];
                p.in_2 = b[NIB_W-1:0];
            end
            COMPUTE_2: begin
                p.in_1 = a[OP_W-1:NIB_W];
                p.in_2 = b[NIB_W-1:0];
            end
            COMPUTE_3: begin
                p.in_1 = a[NIB_W-1:0];
                p.in_2 = b[OP_W-1:NIB_W];
            end
            COMPUTE_4: begin
                p.in_1 = a[OP_W-1:NIB_W];
                p.in_2 = b[OP_W-1:NIB_W];
            end
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/hex_mul_seq_if.sv
// Operand/product handshake bundle of the hex multiplier sequencer.
// master = operand source / product consumer, slave = sequencer.
interface hex_mul_seq_if
    import hex_mul_pkg::*;
();

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] out_product;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_product
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_product
    );

endinterface

// File: rtl/hex_mul_seq.sv
// Sequencer for the nibble-serial hex multiplier. Captures an 8x8 operand pair,
// walks the datapath through four nibble products, sums the returned pre-shifted
// partial products and presents the 16-bit result until it is taken.
module hex_mul_seq
    import hex_mul_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    hex_mul_seq_if.slave       bus,
    output logic [STATE_W-1:0] mul_state,
    output logic [NIB_W-1:0]   mul_in_1,
    output logic [NIB_W-1:0]   mul_in_2,
    input  logic [PROD_W-1:0]  mul_out
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [PROD_W-1:0] out_product_q, out_product_d;
    nib_pair_t         nib;

    // Next state, operand capture and accumulation, plus the registered outputs
    // derived from the next state so they line up with the state register.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    acc_d   = '0;
                    state_d = COMPUTE_1;
                end
            end
            COMPUTE_1: state_d = COMPUTE_2;
            // mul_out here is the partial product issued one state earlier.
            COMPUTE_2: begin
                acc_d   = acc_q + mul_out;
                state_d = COMPUTE_3;
            end
            COMPUTE_3: begin
                acc_d   = acc_q + mul_out;
                state_d = COMPUTE_4;
            end
            COMPUTE_4: begin
                acc_d   = acc_q + mul_out;
                state_d = COMPUTE_5;
            end
            COMPUTE_5: begin
                acc_d   = acc_q + mul_out;
                state_d = COMPUTE_6;
            end
            COMPUTE_6: begin
                // Returning to IDLE only; a new pair is taken on a later edge.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d    = (state_d == IDLE);
        out_valid_d   = (state_d == COMPUTE_6);
        out_product_d = out_valid_d ? acc_d : '0;
    end

    // Single state/output register bank; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            a_q           <= '0;
            b_q           <= '0;
            acc_q         <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            acc_q         <= acc_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
        end
    end

    // Nibble operands follow the current state combinationally.
    always_comb begin
        nib = nib_sel(state_q, a_q, b_q);
    end

    assign mul_state       = state_q;
    assign mul_in_1        = nib.in_1;
    assign mul_in_2        = nib.in_2;
    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;

endmodule

// File: tb/tb_hex_mul_seq.sv
// Self-checking bench for hex_mul_seq: models the 1-cycle datapath, drives
// directed and random operand pairs and compares against a*b and the expected
// nibble schedule.
module tb_hex_mul_seq;
    import hex_mul_pkg::*;

    logic               clk;
    logic               rst_n;
    logic [STATE_W-1:0] mul_state;
    logic [NIB_W-1:0]   mul_in_1;
    logic [NIB_W-1:0]   mul_in_2;
    logic [PROD_W-1:0]  mul_out;

    int checks   = 0;
    int failures = 0;

    hex_mul_seq_if bus ();

    hex_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mul_state (mul_state),
        .mul_in_1  (mul_in_1),
        .mul_in_2  (mul_in_2),
        .mul_out   (mul_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] nib_mul(input logic [3:0] x, input logic [3:0] y);
        return 16'(x) * 16'(y);
    endfunction

    // Datapath stand-in: registered nibble product, pre-shifted by nibble position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_out <= '0;
        end else begin
            case (mul_state)
                3'd1:    mul_out <= nib_mul(mul_in_1, mul_in_2);
                3'd2:    mul_out <= nib_mul(mul_in_1, mul_in_2) << 4;
                3'd3:    mul_out <= nib_mul(mul_in_1, mul_in_2) << 4;
                3'd4:    mul_out <= nib_mul(mul_in_1, mul_in_2) << 8;
                default: mul_out <= '0;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check_eq({tag, "_product"}, 32'(bus.out_product), 0);
        check_eq({tag, "_state"}, 32'(mul_state), 0);
        check_eq({tag, "_nib1"}, 32'(mul_in_1), 0);
        check_eq({tag, "_nib2"}, 32'(mul_in_2), 0);
    endtask

    // Entered at a negedge with the DUT idle; leaves at a negedge with it idle again.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int bp,
                          input bit busy);
        logic [15:0] exp_p;
        logic [3:0]  exp1 [4];
        logic [3:0]  exp2 [4];
        exp_p = {8'd0, a} * {8'd0, b};
        exp1  = '{a[3:0], a[7:4], a[3:0], a[7:4]};
        exp2  = '{b[3:0], b[3:0], b[7:4], b[7:4]};

        check_eq("accept_in_ready", 32'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = (bp == 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("run_state", 32'(mul_state), k + 1);
            check_eq("run_in_ready", 32'(bus.in_ready), 0);
            check_eq("run_out_valid", 32'(bus.out_valid), 0);
            check_eq("run_product", 32'(bus.out_product), 0);
            check_eq("run_nib1", 32'(mul_in_1), (k < 4) ? 32'(exp1[k]) : 0);
            check_eq("run_nib2", 32'(mul_in_2), (k < 4) ? 32'(exp2[k]) : 0);
            if (busy) begin
                bus.in_valid = 1'b1;
                bus.in_a     = 8'($urandom);
                bus.in_b     = 8'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        // Fifth edge after accept: result must be up.
        for (int i = 0; i <= bp; i++) begin
            @(negedge clk);
            check_eq("done_out_valid", 32'(bus.out_valid), 1);
            check_eq("done_product", 32'(bus.out_product), 32'(exp_p));
            check_eq("done_in_ready", 32'(bus.in_ready), 0);
            check_eq("done_state", 32'(mul_state), 6);
            if (busy) begin
                bus.in_a = 8'($urandom);
                bus.in_b = 8'($urandom);
            end
            if (i == bp) bus.out_ready = 1'b1;
        end
        @(negedge clk);
        // A pending in_valid must not be taken on the handshake edge.
        check_idle("handoff");
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        run_op(8'h12, 8'h34, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 0, 1'b0);
        run_op(8'hA5, 8'h5A, 0, 1'b0);
        run_op(8'h00, 8'h7C, 0, 1'b0);
        run_op(8'hC3, 8'h9E, 4, 1'b0);
        run_op(8'h6B, 8'hD7, 2, 1'b1);

        // Reset while in C3 drops the operation without a result.
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h3C;
        bus.in_b     = 8'h99;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("midreset_pre_state", 32'(mul_state), 3);
        rst_n = 1'b0;
        #1;
        check_idle("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("midreset_release");
        run_op(8'h0F, 8'h10, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
            run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
